// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit.
// Multiply: radix-2 shift-add on operand magnitudes, sign applied at the end.
// Divide: restoring shift-subtract on magnitudes, signs applied at the end.
// One result bit per cycle. Divide-by-zero and signed overflow finish in one cycle.
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZEROS  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negation at operand width
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at double (accumulator) width
    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t state_r, state_next_s;

    logic [CW-1:0]     cnt_r;
    logic [2:0]        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   mcand_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   result_r;

    logic              accept_s;
    logic              last_s;
    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic              sign_flag_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic              special_s;
    logic [XLEN-1:0]   special_val_s;

    logic [XLEN:0]     sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     cand_s;
    logic [XLEN:0]     diff_s;
    logic              qbit_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_raw_s;
    logic [XLEN-1:0]   final_s;

    assign accept_s = start & ~kill & (state_r != ST_BUSY);
    assign last_s   = (cnt_r == CNT_LAST);

    // Operand decode at accept: signedness, magnitudes, sign flag, special cases
    always_comb begin
        a_signed_s    = 1'b0;
        b_signed_s    = 1'b0;
        special_val_s = ZEROS;
        case (funct3)
            3'b001: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            3'b100: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        a_neg_s = a_signed_s & a[XLEN-1];
        b_neg_s = b_signed_s & b[XLEN-1];
        abs_a_s = a_neg_s ? neg_x(a) : a;
        abs_b_s = b_neg_s ? neg_x(b) : b;
        // Remainder follows the dividend; every other op follows the product sign
        if (funct3[2:1] == 2'b11) begin
            sign_flag_s = a_neg_s;
        end else begin
            sign_flag_s = a_neg_s ^ b_neg_s;
        end
        if (funct3[2] && (b == ZEROS)) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? a : ONES;
        end else if (funct3[2] && !funct3[0] && (a == MIN_NEG) && (b == ONES)) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? ZEROS : a;
        end else begin
            special_s     = 1'b0;
            special_val_s = ZEROS;
        end
    end

    // One iteration step of shift-add and restoring divide, plus final fix-up
    always_comb begin
        sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, (acc_r[0] ? mcand_r : ZEROS)};
        mul_next_s = {sum_s, acc_r[XLEN-1:1]};
        cand_s     = acc_r[2*XLEN-1:XLEN-1];
        diff_s     = cand_s - {1'b0, mcand_r};
        qbit_s     = ~diff_s[XLEN];
        div_next_s = {(qbit_s ? diff_s[XLEN-1:0] : cand_s[XLEN-1:0]), acc_r[XLEN-2:0], qbit_s};
        acc_next_s = op_r[2] ? div_next_s : mul_next_s;
        prod_s     = neg_r ? neg_2x(mul_next_s) : mul_next_s;
        div_raw_s  = op_r[1] ? div_next_s[2*XLEN-1:XLEN] : div_next_s[XLEN-1:0];
        if (op_r[2]) begin
            final_s = neg_r ? neg_x(div_raw_s) : div_raw_s;
        end else if (op_r[1:0] == 2'b00) begin
            final_s = prod_s[XLEN-1:0];
        end else begin
            final_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic: kill aborts iteration, special cases skip straight to DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_next_s = special_s ? ST_DONE : ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (kill) begin
                    state_next_s = ST_IDLE;
                end else if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture on accept, one step per BUSY cycle, result load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {CW{1'b0}};
            op_r     <= 3'b000;
            neg_r    <= 1'b0;
            mcand_r  <= ZEROS;
            acc_r    <= {2*XLEN{1'b0}};
            result_r <= ZEROS;
        end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            op_r    <= funct3;
            neg_r   <= sign_flag_s;
            mcand_r <= abs_b_s;
            acc_r   <= {ZEROS, abs_a_s};
            if (special_s) begin
                result_r <= special_val_s;
            end
        end else if ((state_r == ST_BUSY) && !kill) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (last_s) begin
                result_r <= final_s;
            end
        end
    end

    assign busy   = (state_r == ST_BUSY);
    assign done   = (state_r == ST_DONE);
    assign result = result_r;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv (XLEN = 32 and XLEN = 16).
module tb_riscv_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic        start16;
    logic        kill16;
    logic [2:0]  funct3_16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] result16;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill),
        .funct3(funct3), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    riscv_muldiv #(.XLEN(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .kill(kill16),
        .funct3(funct3_16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        funct3 = f;
        a      = x;
        b      = y;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts cycles until done is seen, bounded.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
        int n;
        issue(f, x, y);
        wait_done(tag, n);
        check(tag, result, exp);
    endtask

    initial begin
        int n;
        int seen;
        reset     = 1'b1;
        start     = 1'b0;
        kill      = 1'b0;
        funct3    = 3'b000;
        a         = 32'd0;
        b         = 32'd0;
        start16   = 1'b0;
        kill16    = 1'b0;
        funct3_16 = 3'b000;
        a16       = 16'd0;
        b16       = 16'd0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // mul 7 x 6: 32 busy cycles, single done pulse, result held
        issue(3'b000, 32'd7, 32'd6);
        check("mul_busy_start", {31'd0, busy}, 32'd1);
        wait_done("mul", n);
        check("mul_busy_cycles", n, 32'd32);
        check("mul_result", result, 32'd42);
        @(negedge clk);
        check("mul_done_pulse", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("mul_result_held", result, 32'd42);

        // Signed / unsigned multiply-high and signed divide
        run("mulh",   3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        run("mulhu",  3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001);
        run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
        run("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run("div_nb", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run("rem_nb", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1);
        run("divu",   3'b101, 32'd100, 32'd7, 32'd14);
        @(negedge clk);

        // Divide by zero: one-cycle completion, busy never rises
        issue(3'b101, 32'h12345678, 32'd0);
        check("divu0_done", {31'd0, done}, 32'd1);
        check("divu0_busy", {31'd0, busy}, 32'd0);
        check("divu0_result", result, 32'hFFFFFFFF);
        issue(3'b111, 32'h12345678, 32'd0);
        check("remu0_done", {31'd0, done}, 32'd1);
        check("remu0_result", result, 32'h12345678);

        // Signed overflow: one-cycle completion
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF);
        check("divovf_done", {31'd0, done}, 32'd1);
        check("divovf_busy", {31'd0, busy}, 32'd0);
        check("divovf_result", result, 32'h80000000);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF);
        check("removf_done", {31'd0, done}, 32'd1);
        check("removf_result", result, 32'd0);
        @(negedge clk);

        // Back-to-back: start in the DONE cycle
        run("b2b_first", 3'b000, 32'd9, 32'd9, 32'd81);
        check("b2b_in_done", {31'd0, done}, 32'd1);
        issue(3'b000, 32'd11, 32'd11);
        check("b2b_accept", {31'd0, busy}, 32'd1);
        wait_done("b2b_second", n);
        check("b2b_busy_cycles", n, 32'd32);
        check("b2b_result", result, 32'd121);
        @(negedge clk);

        // kill 10 cycles into a divu
        issue(3'b101, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("kill_no_done", seen, 32'd0);
        check("kill_result", result, 32'd121);

        // kill beats start in the same cycle
        funct3 = 3'b000;
        a      = 32'd2;
        b      = 32'd2;
        start  = 1'b1;
        kill   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        kill   = 1'b0;
        check("killstart_busy", {31'd0, busy}, 32'd0);
        check("killstart_done", {31'd0, done}, 32'd0);

        // start pulsed while busy is ignored
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(3'b000, 32'd3, 32'd5);
        wait_done("busy_start", n);
        check("busy_start_result", result, 32'd14);
        @(negedge clk);
        check("busy_start_no_rerun", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset between edges while BUSY
        issue(3'b101, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_done", {31'd0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run("post_reset_mul", 3'b000, 32'd3, 32'd5, 32'd15);

        // XLEN = 16 instance: mul 3 x 5
        funct3_16 = 3'b000;
        a16       = 16'd3;
        b16       = 16'd5;
        start16   = 1'b1;
        @(negedge clk);
        start16   = 1'b0;
        n = 0;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("x16_done", {31'd0, done16}, 32'd1);
        check("x16_busy_cycles", n, 32'd16);
        check("x16_result", {16'd0, result16}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
